vga_timing_gen: RTL and testbench



---
 rtl/vga_timing_gen_pkg.sv | 38 +++
 rtl/vga_timing_gen.sv | 97 +++++++++
 tb/tb_vga_timing_gen.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_pkg.sv
// Shared VGA timing constants and bus layout for the 800x600@60 Hz pipeline.
// Any stage needing the active area or the bus field order imports this package.
package vga_timing_gen_pkg;

  localparam int H_ACTIVE_DEF = 800;
  localparam int H_FP_DEF     = 40;
  localparam int H_SYNC_DEF   = 128;
  localparam int H_BP_DEF     = 88;
  localparam int H_TOTAL_DEF  = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 600;
  localparam int V_FP_DEF     = 1;
  localparam int V_SYNC_DEF   = 4;
  localparam int V_BP_DEF     = 23;
  localparam int V_TOTAL_DEF  = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int CNT_W        = 11;
  localparam int RGB_W        = 12;
  localparam int VGA_BUS_SIZE = 4 + 2 * CNT_W + RGB_W;

  // Field order is the wire order of vga_out, MSB first.
  typedef struct packed {
    logic             hs;
    logic             vs;
    logic             hblnk;
    logic             vblnk;
    logic [CNT_W-1:0] hcount;
    logic [CNT_W-1:0] vcount;
    logic [RGB_W-1:0] rgb;
  } vga_bus_t;

  function automatic logic in_window(input logic [CNT_W-1:0] val,
                                     input logic [CNT_W-1:0] lo,
                                     input logic [CNT_W-1:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Source of the VGA bus: pixel counters, sync, blanking, and frame strobes.
// Every registered field is derived from the next counter values, so all fields describe one pixel.
module vga_timing_gen
  import vga_timing_gen_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int HS_POL   = 1,
  parameter int VS_POL   = 1
)(
  input  logic                    pclk,
  input  logic                    rst,
  output logic [VGA_BUS_SIZE-1:0] vga_out,
  output logic                    frame_start,
  output logic                    vblank_start,
  output logic [15:0]             frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_LO   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_HI   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_LO   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_HI   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic             HS_ACT  = (HS_POL != 0);
  localparam logic             VS_ACT  = (VS_POL != 0);

  logic [CNT_W-1:0] hcount_p0, vcount_p0;
  logic             hs_p0, vs_p0, hblnk_p0, vblnk_p0;
  logic             frame_start_p0, vblank_start_p0;
  logic [15:0]      frame_cnt_p0;

  logic [CNT_W-1:0] hcount_nxt, vcount_nxt;
  logic             h_wrap, v_wrap, frame_wrap;

  always_comb begin
    h_wrap     = (hcount_p0 == H_LAST);
    v_wrap     = (vcount_p0 == V_LAST);
    frame_wrap = h_wrap && v_wrap;
    hcount_nxt = h_wrap ? '0 : hcount_p0 + 1'b1;
    vcount_nxt = vcount_p0;
    if (h_wrap) begin
      vcount_nxt = v_wrap ? '0 : vcount_p0 + 1'b1;
    end
    // Reset discards the current position; the bus shows (0,0) next cycle.
    if (rst) begin
      hcount_nxt = '0;
      vcount_nxt = '0;
    end
  end

  // Stage p0: every output register loads from the next counter values.
  always_ff @(posedge pclk) begin
    hcount_p0       <= hcount_nxt;
    vcount_p0       <= vcount_nxt;
    hblnk_p0        <= (hcount_nxt >= H_ACT_C);
    vblnk_p0        <= (vcount_nxt >= V_ACT_C);
    hs_p0           <= in_window(hcount_nxt, HS_LO, HS_HI) ? HS_ACT : ~HS_ACT;
    vs_p0           <= in_window(vcount_nxt, VS_LO, VS_HI) ? VS_ACT : ~VS_ACT;
    frame_start_p0  <= !rst && frame_wrap;
    vblank_start_p0 <= !rst && h_wrap && (vcount_nxt == V_ACT_C);
    if (rst) begin
      frame_cnt_p0 <= '0;
    end else if (frame_wrap) begin
      frame_cnt_p0 <= frame_cnt_p0 + 16'd1;
    end
  end

  vga_bus_t bus;

  always_comb begin
    bus.hs     = hs_p0;
    bus.vs     = vs_p0;
    bus.hblnk  = hblnk_p0;
    bus.vblnk  = vblnk_p0;
    bus.hcount = hcount_p0;
    bus.vcount = vcount_p0;
    bus.rgb    = '0;
  end

  assign vga_out      = bus;
  assign frame_start  = frame_start_p0;
  assign vblank_start = vblank_start_p0;
  assign frame_cnt    = frame_cnt_p0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default 800x600 instance for line timing and a
// shrunken 25x13, active-low-sync instance so whole frames fit in a short run.
module tb_vga_timing_gen;

  logic        pclk = 1'b0;
  logic        rst  = 1'b1;
  logic [37:0] bus_d, bus_s;
  logic        fs_d, vbs_d, fs_s, vbs_s;
  logic [15:0] fc_d, fc_s;
  int          passed = 0;
  int          total  = 0;

  always #5 pclk = ~pclk;

  vga_timing_gen dut_d (
    .pclk(pclk), .rst(rst), .vga_out(bus_d),
    .frame_start(fs_d), .vblank_start(vbs_d), .frame_cnt(fc_d)
  );

  // Small timing: H 16+2+4+3=25 (hs 18..21), V 8+1+2+2=13 (vs 9..10), frame 325 cycles.
  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(3),
    .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(0), .VS_POL(0)
  ) dut_s (
    .pclk(pclk), .rst(rst), .vga_out(bus_s),
    .frame_start(fs_s), .vblank_start(vbs_s), .frame_cnt(fc_s)
  );

  logic        hs_d, vs_d, hb_d, vb_d, hs_s, vs_s, hb_s, vb_s;
  logic [10:0] hc_d, vc_d, hc_s, vc_s;
  assign {hs_d, vs_d, hb_d, vb_d} = bus_d[37:34];
  assign hc_d = bus_d[33:23];
  assign vc_d = bus_d[22:12];
  assign {hs_s, vs_s, hb_s, vb_s} = bus_s[37:34];
  assign hc_s = bus_s[33:23];
  assign vc_s = bus_s[22:12];

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (5) step();
    total++; if (bus_d !== 38'd0) $display("FAIL reset_bus_d: got %h expected %h", bus_d, 38'd0); else passed++;
    total++; if (bus_s !== {2'b11, 36'd0}) $display("FAIL reset_bus_s: got %h expected %h", bus_s, {2'b11, 36'd0}); else passed++;
    total++; if ({fs_d, vbs_d, fc_d} !== 18'd0) $display("FAIL reset_pulses_d: got %h expected 0", {fs_d, vbs_d, fc_d}); else passed++;
    total++; if ({fs_s, vbs_s, fc_s} !== 18'd0) $display("FAIL reset_pulses_s: got %h expected 0", {fs_s, vbs_s, fc_s}); else passed++;
    rst = 1'b0;
    step();
    total++; if ({hc_d, vc_d, fs_d, fc_d} !== {11'd1, 11'd0, 1'b0, 16'd0})
      $display("FAIL first_cycle_d: got h=%0d v=%0d fs=%b fc=%0d expected h=1 v=0 fs=0 fc=0", hc_d, vc_d, fs_d, fc_d); else passed++;
    total++; if (bus_s !== {2'b11, 2'b00, 11'd1, 11'd0, 12'd0})
      $display("FAIL first_cycle_s: got %h expected %h", bus_s, {2'b11, 2'b00, 11'd1, 11'd0, 12'd0}); else passed++;
    total++; if ({fs_s, vbs_s, fc_s} !== 18'd0) $display("FAIL first_pulses_s: got %h expected 0", {fs_s, vbs_s, fc_s}); else passed++;
  endtask

  task automatic test_line();
    int n = 0;
    int hs_n = 0, hs_first = -1, hs_last = -1, hb_n = 0, hb_first = -1;
    while (hc_d !== 11'd1055 && n < 1100) begin step(); n++; end
    total++; if (hc_d !== 11'd1055) $display("FAIL line_end_timeout: got h=%0d expected 1055", hc_d); else passed++;
    total++; if ({vc_d, hb_d, hs_d} !== {11'd0, 1'b1, 1'b0})
      $display("FAIL line_end_fields: got v=%0d hb=%b hs=%b expected v=0 hb=1 hs=0", vc_d, hb_d, hs_d); else passed++;
    step();
    total++; if ({hc_d, vc_d, hb_d} !== {11'd0, 11'd1, 1'b0})
      $display("FAIL line_wrap: got h=%0d v=%0d hb=%b expected h=0 v=1 hb=0", hc_d, vc_d, hb_d); else passed++;
    for (int i = 0; i < 1056; i++) begin
      if (hs_d) begin hs_n++; if (hs_first < 0) hs_first = int'(hc_d); hs_last = int'(hc_d); end
      if (hb_d) begin hb_n++; if (hb_first < 0) hb_first = int'(hc_d); end
      step();
    end
    total++; if (hs_n != 128) $display("FAIL hs_width: got %0d expected 128", hs_n); else passed++;
    total++; if (hs_first != 840 || hs_last != 967)
      $display("FAIL hs_window: got %0d..%0d expected 840..967", hs_first, hs_last); else passed++;
    total++; if (hb_n != 256 || hb_first != 800)
      $display("FAIL hblnk_window: got first=%0d count=%0d expected first=800 count=256", hb_first, hb_n); else passed++;
    total++; if ({hc_d, vc_d, hb_d, hs_d, vb_d, vs_d} !== {11'd0, 11'd2, 4'b0000})
      $display("FAIL line2_start: got h=%0d v=%0d hb=%b hs=%b vb=%b vs=%b expected h=0 v=2 all flags 0",
               hc_d, vc_d, hb_d, hs_d, vb_d, vs_d); else passed++;
  endtask

  task automatic test_vertical();
    int n = 0;
    int vb_n = 0, vb_first = -1, vs_n = 0, vs_first = -1, vs_last = -1;
    int vs_bad = 0, hs_n = 0, vbs_n = 0, vbs_h = -1, vbs_v = -1, fs_n = 0;
    logic vs_prev;
    while (!(hc_s == 11'd0 && vc_s == 11'd0) && n < 400) begin step(); n++; end
    total++; if ({hc_s, vc_s, fs_s} !== {22'd0, 1'b1})
      $display("FAIL wrap_to_origin_s: got h=%0d v=%0d fs=%b expected h=0 v=0 fs=1", hc_s, vc_s, fs_s); else passed++;
    vs_prev = vs_s;
    for (int i = 0; i < 325; i++) begin
      step();
      if (vb_s) begin vb_n++; if (vb_first < 0) vb_first = int'(vc_s); end
      if (!vs_s) begin vs_n++; if (vs_first < 0) vs_first = int'(vc_s); vs_last = int'(vc_s); end
      if (vs_s != vs_prev && hc_s != 11'd0) vs_bad++;
      vs_prev = vs_s;
      if (!hs_s) hs_n++;
      if (vbs_s) begin vbs_n++; vbs_h = int'(hc_s); vbs_v = int'(vc_s); end
      if (fs_s) fs_n++;
    end
    total++; if (vb_n != 125 || vb_first != 8)
      $display("FAIL vblnk_window: got first=%0d count=%0d expected first=8 count=125", vb_first, vb_n); else passed++;
    total++; if (vs_n != 50 || vs_first != 9 || vs_last != 10)
      $display("FAIL vs_window: got %0d..%0d count=%0d expected 9..10 count=50", vs_first, vs_last, vs_n); else passed++;
    total++; if (vs_bad != 0) $display("FAIL vs_mid_line: got %0d changes expected 0", vs_bad); else passed++;
    total++; if (hs_n != 52) $display("FAIL hs_per_frame_s: got %0d expected 52", hs_n); else passed++;
    total++; if (vbs_n != 1 || vbs_h != 0 || vbs_v != 8)
      $display("FAIL vblank_start: got count=%0d at (%0d,%0d) expected count=1 at (0,8)", vbs_n, vbs_h, vbs_v); else passed++;
    total++; if (fs_n != 1 || fs_s !== 1'b1)
      $display("FAIL frame_start_per_frame: got count=%0d last=%b expected count=1 last=1", fs_n, fs_s); else passed++;
  endtask

  task automatic test_frame();
    int k;
    rst = 1'b1;
    step();
    total++; if ({hc_s, vc_s, fs_s, vbs_s, fc_s} !== 40'd0)
      $display("FAIL frame_reset_s: got h=%0d v=%0d fs=%b vbs=%b fc=%0d expected all 0", hc_s, vc_s, fs_s, vbs_s, fc_s); else passed++;
    rst = 1'b0;
    for (int f = 1; f <= 3; f++) begin
      k = 0;
      do begin step(); k++; end while (!fs_s && k < 400);
      total++; if (k != 325) $display("FAIL frame%0d_period: got %0d expected 325", f, k); else passed++;
      total++; if ({hc_s, vc_s, fc_s} !== {22'd0, 16'(f)})
        $display("FAIL frame%0d_pulse: got h=%0d v=%0d fc=%0d expected h=0 v=0 fc=%0d", f, hc_s, vc_s, fc_s, f); else passed++;
    end
    step();
    total++; if ({fs_s, fc_s} !== {1'b0, 16'd3})
      $display("FAIL frame_pulse_width: got fs=%b fc=%0d expected fs=0 fc=3", fs_s, fc_s); else passed++;
  endtask

  task automatic test_mid_reset();
    int n = 0;
    int k = 1;
    while (!(hc_s == 11'd12 && vc_s == 11'd6) && n < 400) begin step(); n++; end
    total++; if ({hc_s, vc_s} !== {11'd12, 11'd6}) $display("FAIL mid_wait: got (%0d,%0d) expected (12,6)", hc_s, vc_s); else passed++;
    rst = 1'b1;
    step();
    total++; if (bus_s !== {2'b11, 36'd0}) $display("FAIL mid_reset_bus_s: got %h expected %h", bus_s, {2'b11, 36'd0}); else passed++;
    total++; if ({fs_s, vbs_s, fc_s} !== 18'd0) $display("FAIL mid_reset_pulses_s: got %h expected 0", {fs_s, vbs_s, fc_s}); else passed++;
    total++; if ({bus_d, fs_d, vbs_d, fc_d} !== 56'd0) $display("FAIL mid_reset_d: got %h expected 0", {bus_d, fs_d, vbs_d, fc_d}); else passed++;
    rst = 1'b0;
    step();
    total++; if ({hc_s, vc_s, fs_s} !== {11'd1, 11'd0, 1'b0})
      $display("FAIL mid_resume: got h=%0d v=%0d fs=%b expected h=1 v=0 fs=0", hc_s, vc_s, fs_s); else passed++;
    while (!fs_s && k < 400) begin step(); k++; end
    total++; if (k != 325 || fc_s !== 16'd1)
      $display("FAIL mid_next_frame: got period=%0d fc=%0d expected period=325 fc=1", k, fc_s); else passed++;
  endtask

  initial begin
    test_reset();
    test_line();
    test_vertical();
    test_frame();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
